// File: rtl/mont_mul_ctrl_if.sv
// Request/response bundle between the scheduler and the Montgomery multiplier sequencer.
// The scheduler holds the master modport and the sequencer holds the slave modport.
interface mont_mul_ctrl_if;
   logic         start;
   logic [255:0] a_in;
   logic [255:0] b_in;
   logic [255:0] m_in;
   logic         busy;
   logic         done;
   logic         err;
   logic [255:0] result;

   modport master (
      output start, a_in, b_in, m_in,
      input  busy, done, err, result
   );

   modport slave (
      input  start, a_in, b_in, m_in,
      output busy, done, err, result
   );
endinterface

// File: rtl/mont_mul_ctrl.sv
// Radix-2 Montgomery multiplier sequencer: 256 add-and-halve passes and one
// conditional subtract, all through a single three-operand adder.
module csa_256 (
   input  logic [255:0] a,
   input  logic [255:0] b,
   input  logic [255:0] c,
   output logic [256:0] sum,
   output logic         cout
);
   logic [257:0] full;

   assign full = {2'b00, a} + {2'b00, b} + {2'b00, c};
   assign sum  = full[256:0];
   assign cout = full[257];
endmodule

module mont_mul_ctrl (
   input  logic           clk,
   input  logic           rst_n,
   mont_mul_ctrl_if.slave bus
);
   localparam int N = 256;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ITER,
      S_CORR,
      S_ERR,
      S_DONE
   } state_t;

   state_t       state_q;
   logic [N-1:0] a_q, b_q, m_q, r_q, result_q;
   logic [7:0]   cnt_q;
   logic         busy_q, done_q, err_q;

   logic [N-1:0] add_a, add_b, add_c;
   logic [N:0]   add_sum;
   logic         cout_unused;
   logic         ai, qi, m_ok;

   assign m_ok = bus.m_in[0] & ~bus.m_in[N-1];

   // The adder is shared: CORR computes R + ~M + 1 = R - M + 2^256, so sum[N] flags R >= M.
   always_comb begin
      ai    = a_q[cnt_q];
      qi    = r_q[0] ^ (ai & b_q[0]);
      add_a = r_q;
      add_b = '0;
      add_c = '0;
      if (state_q == S_CORR) begin
         add_b = ~m_q;
         add_c = {{(N-1){1'b0}}, 1'b1};
      end else begin
         add_b = ai ? b_q : '0;
         add_c = qi ? m_q : '0;
      end
   end

   csa_256 u_adder (
      .a    (add_a),
      .b    (add_b),
      .c    (add_c),
      .sum  (add_sum),
      .cout (cout_unused)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         m_q      <= '0;
         r_q      <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  busy_q <= 1'b1;
                  if (m_ok) begin
                     a_q     <= bus.a_in;
                     b_q     <= bus.b_in;
                     m_q     <= bus.m_in;
                     r_q     <= '0;
                     cnt_q   <= '0;
                     state_q <= S_ITER;
                  end else begin
                     state_q <= S_ERR;
                  end
               end
            end
            S_ITER: begin
               // The sum is always even here, so dropping bit 0 is an exact halving.
               r_q   <= add_sum[N:1];
               cnt_q <= cnt_q + 8'd1;
               if (cnt_q == 8'd255) begin
                  state_q <= S_CORR;
               end
            end
            S_CORR: begin
               result_q <= add_sum[N] ? add_sum[N-1:0] : r_q;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
               state_q  <= S_DONE;
            end
            S_ERR: begin
               result_q <= '0;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
               err_q    <= 1'b1;
               state_q  <= S_DONE;
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.err    = err_q;
   assign bus.result = result_q;
endmodule
